// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester (fetch / data) arbiter onto one single-outstanding memory port.
// Ports: clock, reset (sync, active-low);
//   fetch side  if_req, if_addr -> if_rdata, if_valid, stall_if;
//   data side   mem_rd, mem_wr, mem_addr, mem_wdata -> mem_rdata, mem_valid, stall_mem;
//   memory side mreq, mwe, maddr, mwdata -> mrdata, mready; proto_err (sticky rd+wr collision).
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] if_rdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              if_valid,
  output logic              mem_valid,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mreq,
  output logic              mwe,
  output logic [ADDR_W-1:0] maddr,
  output logic [DATA_W-1:0] mwdata,
  input  logic [DATA_W-1:0] mrdata,
  input  logic              mready,
  output logic              proto_err
);
  localparam logic [1:0] IDLE = 2'd0, BUSY_IF = 2'd1, BUSY_MEM = 2'd2;
  localparam logic [2:0] STREAK_MAX = 3'(MAX_STREAK);
  logic [1:0] state;
  logic [2:0] streak;
  logic memReq, memWins;
  assign memReq = mem_rd | mem_wr;
  // the data stage wins ties until it has starved a waiting fetch MAX_STREAK times in a row
  assign memWins = memReq && !(if_req && streak == STREAK_MAX);
  assign stall_if = if_req && !if_valid;
  assign stall_mem = memReq && !mem_valid;
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      streak <= '0;
      mreq <= 1'b0;
      mwe <= 1'b0;
      maddr <= '0;
      mwdata <= '0;
      if_rdata <= '0;
      mem_rdata <= '0;
      if_valid <= 1'b0;
      mem_valid <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      mem_valid <= 1'b0;
      if (mem_rd && mem_wr) proto_err <= 1'b1;
      if (state == IDLE) begin
        if (memWins) begin
          state <= BUSY_MEM;
          mreq <= 1'b1;
          maddr <= mem_addr;
          mwe <= mem_wr;
          mwdata <= mem_wdata;
          streak <= !if_req ? 3'd0 : (streak == STREAK_MAX ? streak : streak + 3'd1);
        end else if (if_req) begin
          state <= BUSY_IF;
          mreq <= 1'b1;
          mwe <= 1'b0;
          maddr <= if_addr;
          streak <= '0;
        end
      end else if (mready) begin
        state <= IDLE;
        mreq <= 1'b0;
        if (state == BUSY_IF) begin
          if_valid <= 1'b1;
          if_rdata <= mrdata;
        end else begin
          mem_valid <= 1'b1;
          // stores leave the last load result in place
          if (!mwe) mem_rdata <= mrdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed scoreboard bench for mem_port_arbiter.
module tb_mem_port_arbiter;
  localparam int MAXS = 4;
  logic clk = 0, reset = 0;
  logic if_req = 0, mem_rd = 0, mem_wr = 0, mready, proto_err;
  logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0, mrdata;
  logic [31:0] if_rdata, mem_rdata, maddr, mwdata;
  logic if_valid, mem_valid, stall_if, stall_mem, mreq, mwe;
  int total = 0, bad = 0;
  logic [31:0] ifQ[$], memQ[$];
  bit grantLog[$];
  logic [31:0] lastMem = 0;
  bit override = 0;
  logic [31:0] ovVal = 0;
  int forceWait = -1;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(MAXS)) dut (
    .clock(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .if_rdata(if_rdata), .mem_rdata(mem_rdata),
    .if_valid(if_valid), .mem_valid(mem_valid), .stall_if(stall_if), .stall_mem(stall_mem),
    .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata), .mrdata(mrdata), .mready(mready),
    .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event seen/missing contrary to model", name);
  endtask
  task automatic chkAllZero();
    chk("rst_mreq", {31'd0, mreq}, 0);
    chk("rst_mwe", {31'd0, mwe}, 0);
    chk("rst_maddr", maddr, 0);
    chk("rst_mwdata", mwdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_valids", {30'd0, if_valid, mem_valid}, 0);
    chk("rst_proto_err", {31'd0, proto_err}, 0);
  endtask
  task automatic doReset();
    reset = 0;
    lastMem = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chkAllZero();
    @(posedge clk);
    #2;
    reset = 1;
  endtask
  task automatic ifTxn(input logic [31:0] a, output int lat);
    if_addr = a;
    if_req = 1;
    ifQ.push_back(override ? ovVal : f(a));
    lat = 0;
    do begin
      @(posedge clk);
      #2;
      lat++;
    end while (!if_valid && lat < 300);
    if (!if_valid) fail("if_timeout");
    if_req = 0;
  endtask
  task automatic memTxn(input int kind, input logic [31:0] a, input logic [31:0] d, output int lat);
    mem_addr = a;
    mem_wdata = d;
    mem_rd = (kind != 1);
    mem_wr = (kind != 0);
    memQ.push_back(kind == 0 ? f(a) : lastMem);
    if (kind == 0) lastMem = f(a);
    lat = 0;
    do begin
      @(posedge clk);
      #2;
      lat++;
    end while (!mem_valid && lat < 300);
    if (!mem_valid) fail("mem_timeout");
    mem_rd = 0;
    mem_wr = 0;
  endtask
  // memory responder plus transaction-level arbitration model
  bit active = 0, pRst = 0, pIdle = 1, pIf = 0, pRd = 0, pWr = 0, pMem = 0, pReady = 0, proto = 0;
  bit idleNow, mw, hMem, hWe;
  logic [31:0] pIfA = 0, pMemA = 0, pWd = 0, hA = 0, hD = 0;
  int waitLeft = 0, streak = 0;
  initial begin
    mready = 0;
    mrdata = 0;
    forever begin
      @(negedge clk);
      idleNow = 0;
      if (!pRst) begin
        chk("reset_mreq", {31'd0, mreq}, 0);
        active = 0;
        streak = 0;
        proto = 0;
        idleNow = 1;
      end else begin
        if (pRd && pWr) proto = 1;
        if (pIdle) begin
          if (pIf || pMem) begin
            mw = pMem && !(pIf && streak == MAXS);
            hMem = mw;
            hA = mw ? pMemA : pIfA;
            hWe = mw && pWr;
            hD = pWd;
            chk("grant_mreq", {31'd0, mreq}, 1);
            chk("grant_maddr", maddr, hA);
            chk("grant_mwe", {31'd0, mwe}, {31'd0, hWe});
            if (hMem) chk("grant_mwdata", mwdata, hD);
            grantLog.push_back(mw);
            streak = mw ? (pIf ? (streak < MAXS ? streak + 1 : MAXS) : 0) : 0;
            active = 1;
            waitLeft = forceWait >= 0 ? forceWait : int'($urandom_range(0, 3));
          end else begin
            chk("idle_mreq", {31'd0, mreq}, 0);
            idleNow = 1;
          end
        end else if (pReady) begin
          chk("done_mreq", {31'd0, mreq}, 0);
          active = 0;
          idleNow = 1;
        end else begin
          chk("hold_mreq", {31'd0, mreq}, 1);
          chk("hold_maddr", maddr, hA);
          chk("hold_mwe", {31'd0, mwe}, {31'd0, hWe});
          if (hMem) chk("hold_mwdata", mwdata, hD);
        end
      end
      chk("proto_err", {31'd0, proto_err}, {31'd0, proto});
      pIdle = idleNow;
      pRst = reset;
      pIf = if_req;
      pRd = mem_rd;
      pWr = mem_wr;
      pMem = mem_rd | mem_wr;
      pIfA = if_addr;
      pMemA = mem_addr;
      pWd = mem_wdata;
      if (active) begin
        pReady = (waitLeft == 0);
        waitLeft--;
        mready = pReady;
        mrdata = override ? ovVal : f(hA);
      end else begin
        pReady = 0;
        mready = ($urandom_range(0, 3) == 0);
        mrdata = $urandom;
      end
    end
  end
  // completion monitor: pops the scoreboard on every valid pulse
  initial forever begin
    @(negedge clk);
    if (if_valid) begin
      if (ifQ.size() == 0) fail("if_valid_unexpected");
      else chk("if_rdata", if_rdata, ifQ.pop_front());
    end
    if (mem_valid) begin
      if (memQ.size() == 0) fail("mem_valid_unexpected");
      else chk("mem_rdata", mem_rdata, memQ.pop_front());
    end
    chk("valid_exclusive", {31'd0, if_valid & mem_valid}, 0);
    chk("stall_if", {31'd0, stall_if}, {31'd0, if_req & ~if_valid});
    chk("stall_mem", {31'd0, stall_mem}, {31'd0, (mem_rd | mem_wr) & ~mem_valid});
  end
  initial begin
    int lat, n;
    doReset();
    override = 1;
    ovVal = 32'h8C220004;
    forceWait = 0;
    ifTxn(32'h40, lat);
    chk("if_latency", lat, 2);
    chk("if_rdata_directed", if_rdata, 32'h8C220004);
    override = 0;
    memTxn(0, 32'h24, 32'h0, lat);
    chk("mem_read_latency", lat, 2);
    forceWait = 3;
    memTxn(1, 32'h20, 32'hDEADBEEF, lat);
    chk("store_wait_latency", lat, 5);
    chk("store_keeps_rdata", mem_rdata, f(32'h24));
    forceWait = -1;
    memTxn(2, 32'h30, 32'h12345678, lat);
    repeat (4) @(posedge clk);
    #2;
    chk("proto_sticky", {31'd0, proto_err}, 1);
    doReset();
    grantLog.delete();
    fork
      ifTxn(32'h80, lat);
      begin
        int l;
        repeat (6) memTxn(0, 32'h100 + 32'($urandom_range(0, 15) * 4), 32'h0, l);
      end
    join
    if (grantLog.size() < 5) fail("starve_log_short");
    else for (int i = 0; i < 5; i++) chk("starve_order", {31'd0, grantLog[i]}, (i < 4) ? 1 : 0);
    fork
      for (int i = 0; i < 60; i++) begin
        int l;
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #2;
        end
        ifTxn($urandom, l);
      end
      for (int j = 0; j < 60; j++) begin
        int l, k;
        k = $urandom_range(0, 9);
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #2;
        end
        memTxn(k == 0 ? 2 : (k < 5 ? 0 : 1), $urandom, $urandom, l);
      end
    join
    forceWait = 20;
    mem_wr = 1;
    mem_addr = 32'h20;
    mem_wdata = 32'hDEADBEEF;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!mreq && n < 20);
    if (!mreq) fail("busy_wait_timeout");
    @(posedge clk);
    #2;
    reset = 0;
    mem_wr = 0;
    lastMem = 0;
    @(posedge clk);
    @(negedge clk);
    chkAllZero();
    repeat (3) begin
      @(negedge clk);
      chk("no_valid_after_abort", {31'd0, mem_valid}, 0);
    end
    @(posedge clk);
    #2;
    reset = 1;
    forceWait = -1;
    repeat (4) @(posedge clk);
    if (ifQ.size() != 0 || memQ.size() != 0) fail("scoreboard_leftover");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of both requesters and the memory port.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter MAX_STREAK, default 4, maximum consecutive MEM grants while IF waits (range 1-7).
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-006 if_req  input  1  instruction-fetch request; held high until if_valid.
REQ-007 if_addr  input  ADDR_W  fetch address; stable while if_req is high.
REQ-008 mem_rd / mem_wr  input  1 each  data-stage load / store request; held until mem_valid.
REQ-009 mem_addr, mem_wdata  input  ADDR_W, DATA_W  data address and store data; stable while a request is high.
REQ-010 if_rdata, mem_rdata  output  DATA_W  registered read data per requester.
REQ-011 if_valid, mem_valid  output  1  one-cycle completion pulse per requester.
REQ-012 stall_if, stall_mem  output  1  combinational stall: request high and its valid low.
REQ-013 mreq, mwe  output  1  memory request and write enable, registered.
REQ-014 maddr, mwdata  output  ADDR_W, DATA_W  registered memory address and write data.
REQ-015 mrdata  input  DATA_W; mready  input  1  memory read data and completion, valid in the same cycle.
REQ-016 proto_err  output  1  sticky flag, set when mem_rd and mem_wr are both high.

Function
REQ-017 FSM states: IDLE, BUSY_IF, BUSY_MEM.
REQ-018 IDLE with no request: mreq=0, state stays IDLE.
REQ-019 IDLE with only the MEM request: grant MEM; next cycle BUSY_MEM, mreq=1, maddr=mem_addr, mwe=mem_wr, mwdata=mem_wdata.
REQ-020 IDLE with only if_req: grant IF; next cycle BUSY_IF, mreq=1, mwe=0, maddr=if_addr.
REQ-021 Both requesting: MEM wins unless streak==MAX_STREAK, in which case IF wins.
REQ-022 streak: 3-bit counter; +1 on each MEM grant taken while if_req is high; cleared on any IF grant and on a MEM grant taken while if_req is low; saturates at MAX_STREAK.
REQ-023 BUSY_x with mready=0: hold mreq, maddr, mwe and mwdata unchanged; no upper bound on the wait.
REQ-024 BUSY_x with mready=1: mreq=0 and state IDLE on the next edge; x_valid pulses high that next cycle.
REQ-025 On IF completion, if_rdata is loaded from mrdata. On MEM read completion, mem_rdata is loaded from mrdata. On MEM write completion, mem_rdata holds its previous value.
REQ-026 Minimum latency: request seen in IDLE at edge N, mreq high in cycle N+1, mready in N+1 gives valid in cycle N+2.
REQ-027 Arbitration happens only in IDLE, so there is one idle cycle between back-to-back transactions.
REQ-028 A request that drops before its grant is ignored. A request that drops while in BUSY does not abort the memory access; the valid pulse still occurs.
REQ-029 mem_rd=1 and mem_wr=1 together: treated as a write, and proto_err is set and stays set until reset.
REQ-030 Valid pulses last exactly one cycle; if_valid and mem_valid are never high together.
REQ-031 mready received in IDLE is ignored.

Reset
REQ-032 reset low at an edge: state=IDLE, mreq=0, mwe=0, maddr=0, mwdata=0, if_rdata=0, mem_rdata=0, if_valid=0, mem_valid=0, streak=0, proto_err=0.
REQ-033 Reset during BUSY abandons the access with no valid pulse; the memory port sees mreq=0 from the next cycle.
REQ-034 The first arbitration happens in the first IDLE cycle after reset is released.

Verification
REQ-035 IF read: if_req=1, if_addr=0x40, mready=1 one cycle after mreq, mrdata=0x8C220004 -> maddr=0x40, mwe=0, if_valid pulse 2 cycles after the request, if_rdata=0x8C220004.
REQ-036 Conflict: if_req=1 and mem_rd=1 (addr 0x100) in the same IDLE cycle -> MEM served first, then IF; stall_if high throughout the MEM access.
REQ-037 Starvation guard with MAX_STREAK=4: if_req held high, MEM re-requests back-to-back -> 4 MEM grants, then 1 IF grant, then streak=0.
REQ-038 Store with a 3-cycle wait: mem_wr=1, mem_addr=0x20, mem_wdata=0xDEADBEEF, mready low for 3 cycles -> mwe/maddr/mwdata stable for 4 cycles, one mem_valid pulse, mem_rdata unchanged.
REQ-039 Reset in BUSY_MEM while mready=0 -> next cycle mreq=0, state IDLE, no mem_valid pulse, all outputs at reset values.
REQ-040 mem_rd=1 and mem_wr=1 together -> write performed with mwe=1, proto_err=1, which stays high until reset.
